// File: rtl/fft_bfp_pkg.sv
// Shared types and helpers for the block-floating-point shift-amount generator.
// Contents:
//   LANES, GUARD    lane count per beat and default guard headroom
//   MAX_W           widest legal lane width; hr_t is sized for it
//   hr_t            headroom count type (0..MAX_W-1)
//   stage_state_e   stage-end tracker states
//   leading_sign_hr leading-sign headroom of the low w bits of a lane
package fft_bfp_pkg;

  localparam int LANES = 4;
  localparam int GUARD = 2;
  localparam int MAX_W = 16;

  // Sized for the widest legal lane so every instance shares one type.
  typedef logic [$clog2(MAX_W):0] hr_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } stage_state_e;

  // Counts the bits just below the sign bit that repeat it. This equals
  // (leading bits equal to the MSB) - 1, so zero and all-ones give w-1.
  function automatic hr_t leading_sign_hr(input logic [MAX_W-1:0] d, input int w);
    hr_t  cnt;
    logic run;
    cnt = '0;
    run = 1'b1;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      if (i <= w - 2) begin
        if (run && (d[i] == d[w-1])) begin
          cnt = cnt + hr_t'(1);
        end else begin
          run = 1'b0;
        end
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_intrf.sv
// Minimal AXI-stream handshake bundle: tvalid/tready/tlast.
//   s_axis  receiving side (drives tready)
//   m_axis  sending side (drives tvalid, tlast)
interface axis_intrf;
  logic tvalid;
  logic tready;
  logic tlast;
  modport s_axis (input tvalid, input tlast, output tready);
  modport m_axis (output tvalid, output tlast, input tready);
endinterface

// File: rtl/clk_rstn_intrf.sv
// Clock and reset bundle.
//   clk   single clock
//   rstn  asynchronous active-low reset
interface clk_rstn_intrf;
  logic clk;
  logic rstn;
  modport slave (input clk, input rstn);
endinterface

// File: rtl/bfp_headroom_lane.sv
// Combinational leading-sign headroom counter for one lane.
//   data  lane value, width bits, signed
//   hr    headroom, 0..width-1
module bfp_headroom_lane
  import fft_bfp_pkg::*;
#(
  parameter int width = 8
) (
  input  logic [width-1:0] data,
  output hr_t              hr
);

  logic [MAX_W-1:0] pad_s;

  // Widen to the helper's fixed width; only the low width bits are examined.
  always_comb begin
    pad_s              = '0;
    pad_s[width-1:0]   = data;
  end

  assign hr = leading_sign_hr(pad_s, width);

endmodule

// File: rtl/bfp_shamt_gen.sv
// Write-back side of the block-floating-point scheme. Passes 4-lane beats
// through a one-deep AXI-stream register slice, tracks the minimum sign
// headroom over a stage, and at stage end (tlast beat) produces the right
// shift for the next stage plus the running block exponent.
// Ports:
//   clk_rstn_i     clock / async active-low reset
//   s_axis         input handshake from the butterfly
//   m_axis         output handshake to the memory writer
//   data_i         four signed lanes per beat
//   clear_i        sync clear at the start of a transform
//   data_o         registered lanes
//   shamt_o        right shift for the next stage, held between stage ends
//   shamt_valid_o  one-cycle pulse when shamt_o updates
//   blk_exp_o      saturating sum of all shifts so far
module bfp_shamt_gen
  import fft_bfp_pkg::*;
#(
  parameter int width     = 8,
  parameter int shamtbits = 4,
  parameter int guard     = GUARD,
  parameter int expbits   = 8
) (
  clk_rstn_intrf.slave                      clk_rstn_i,
  axis_intrf.s_axis                         s_axis,
  axis_intrf.m_axis                         m_axis,
  input  logic [0:LANES-1][width-1:0]       data_i,
  input  logic                              clear_i,
  output logic [0:LANES-1][width-1:0]       data_o,
  output logic [shamtbits-1:0]              shamt_o,
  output logic                              shamt_valid_o,
  output logic [expbits-1:0]                blk_exp_o
);

  if (!((width == 8 && shamtbits == 4) || (width == 16 && shamtbits == 5))) begin : g_bad_params
    $error("bfp_shamt_gen: unsupported width/shamtbits pair");
  end

  localparam hr_t HR_INIT  = hr_t'(width - 1);
  localparam hr_t GUARD_HR = hr_t'(guard);

  logic                 full_r;
  logic                 tlast_r;
  logic                 in_hs_s;
  logic                 out_hs_s;
  logic                 stage_end_s;
  stage_state_e         state_r;
  stage_state_e         state_s;
  hr_t                  min_hr_r;
  hr_t                  lane_hr_s [LANES];
  hr_t                  beat_min_s;
  hr_t                  run_min_s;
  hr_t                  stage_min_s;
  logic [shamtbits-1:0] shamt_next_s;
  logic [expbits:0]     exp_sum_s;
  logic [expbits-1:0]   exp_next_s;

  assign s_axis.tready = ~full_r | m_axis.tready;
  assign m_axis.tvalid = full_r;
  assign m_axis.tlast  = tlast_r;
  assign in_hs_s       = s_axis.tvalid & s_axis.tready;
  assign out_hs_s      = full_r & m_axis.tready;
  // A clear on the tlast beat discards that stage's result.
  assign stage_end_s   = in_hs_s & s_axis.tlast & ~clear_i;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bfp_headroom_lane #(.width(width)) u_lane (
      .data (data_i[g]),
      .hr   (lane_hr_s[g])
    );
  end

  // Min-tree over this beat's lanes and the running stage minimum.
  always_comb begin
    beat_min_s = lane_hr_s[0];
    for (int k = 1; k < LANES; k++) begin
      if (lane_hr_s[k] < beat_min_s) begin
        beat_min_s = lane_hr_s[k];
      end else begin
        beat_min_s = beat_min_s;
      end
    end
    // The first beat of a stage starts from the maximum headroom.
    if (state_r == IDLE) begin
      run_min_s = HR_INIT;
    end else begin
      run_min_s = min_hr_r;
    end
    if (beat_min_s < run_min_s) begin
      stage_min_s = beat_min_s;
    end else begin
      stage_min_s = run_min_s;
    end
  end

  // Shift needed to restore guard bits, and the saturating exponent update.
  always_comb begin
    if (stage_min_s >= GUARD_HR) begin
      shamt_next_s = '0;
    end else begin
      shamt_next_s = shamtbits'(GUARD_HR - stage_min_s);
    end
    exp_sum_s = {1'b0, blk_exp_o} + (expbits + 1)'(shamt_next_s);
    if (exp_sum_s[expbits]) begin
      exp_next_s = '1;
    end else begin
      exp_next_s = exp_sum_s[expbits-1:0];
    end
  end

  // Stage tracker next state: a non-last beat opens a stage, tlast or clear closes it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_hs_s && !s_axis.tlast && !clear_i) begin
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (clear_i || (in_hs_s && s_axis.tlast)) begin
          state_s = IDLE;
        end else begin
          state_s = ACCUM;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Register slice: load on input handshake, empty when the consumer takes the beat.
  always_ff @(posedge clk_rstn_i.clk or negedge clk_rstn_i.rstn) begin
    if (!clk_rstn_i.rstn) begin
      full_r  <= 1'b0;
      tlast_r <= 1'b0;
      data_o  <= '0;
    end else if (in_hs_s) begin
      full_r  <= 1'b1;
      tlast_r <= s_axis.tlast;
      data_o  <= data_i;
    end else if (out_hs_s) begin
      full_r  <= 1'b0;
    end
  end

  // Stage state, running minimum, shift amount and block exponent.
  always_ff @(posedge clk_rstn_i.clk or negedge clk_rstn_i.rstn) begin
    if (!clk_rstn_i.rstn) begin
      state_r       <= IDLE;
      min_hr_r      <= HR_INIT;
      shamt_o       <= '0;
      shamt_valid_o <= 1'b0;
      blk_exp_o     <= '0;
    end else begin
      state_r <= state_s;
      if (clear_i) begin
        min_hr_r      <= HR_INIT;
        shamt_o       <= '0;
        shamt_valid_o <= 1'b0;
        blk_exp_o     <= '0;
      end else if (stage_end_s) begin
        min_hr_r      <= HR_INIT;
        shamt_o       <= shamt_next_s;
        shamt_valid_o <= 1'b1;
        blk_exp_o     <= exp_next_s;
      end else begin
        shamt_valid_o <= 1'b0;
        if (in_hs_s) begin
          min_hr_r <= stage_min_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_bfp_shamt_gen.sv
// Self-checking bench for bfp_shamt_gen (width=8): a table of single-beat
// stages plus directed sequences for multi-beat stages, saturation,
// back-pressure, clear and asynchronous reset.
module tb_bfp_shamt_gen;

  typedef logic [0:3][7:0] beat_t;
  typedef struct {
    beat_t      lanes;
    logic [3:0] shamt;
    logic [7:0] bexp;
  } vec_t;

  clk_rstn_intrf cr ();
  axis_intrf     s_if ();
  axis_intrf     m_if ();

  beat_t      data_i;
  beat_t      data_o;
  logic       clear_i;
  logic [3:0] shamt_o;
  logic       shamt_valid_o;
  logic [7:0] blk_exp_o;

  int checks = 0;
  int errors = 0;

  bfp_shamt_gen #(.width(8), .shamtbits(4), .guard(2), .expbits(8)) dut (
    .clk_rstn_i    (cr),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .data_i        (data_i),
    .clear_i       (clear_i),
    .data_o        (data_o),
    .shamt_o       (shamt_o),
    .shamt_valid_o (shamt_valid_o),
    .blk_exp_o     (blk_exp_o)
  );

  initial begin
    cr.clk = 1'b0;
    forever #5 cr.clk = ~cr.clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One handshaked beat; returns 1 time unit after the capturing edge.
  task automatic send(input beat_t d, input logic last, input logic clr);
    data_i      = d;
    s_if.tvalid = 1'b1;
    s_if.tlast  = last;
    clear_i     = clr;
    @(posedge cr.clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge cr.clk);
    #1;
  endtask

  function automatic beat_t mk(input int b);
    return {8'(4 * b + 1), 8'(4 * b + 2), 8'(4 * b + 3), 8'(4 * b + 4)};
  endfunction

  vec_t  vecs [8];
  beat_t exp_q [$];
  int    sent;
  int    rcvd;
  logic  mfull;
  logic  exp_tready;
  logic  in_hs;
  logic  out_hs;

  initial begin
    vecs[0] = '{32'h10101010, 4'd0, 8'd0};
    vecs[1] = '{32'h007F1010, 4'd2, 8'd2};
    vecs[2] = '{32'hC00000FF, 4'd1, 8'd3};
    vecs[3] = '{32'h00FF00FF, 4'd0, 8'd3};
    vecs[4] = '{32'h10101080, 4'd2, 8'd5};
    vecs[5] = '{32'h20FF0010, 4'd1, 8'd6};
    vecs[6] = '{32'hE010FF00, 4'd0, 8'd6};
    vecs[7] = '{32'h00003F00, 4'd1, 8'd7};

    cr.rstn     = 1'b0;
    data_i      = '0;
    clear_i     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge cr.clk);
    #1;
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_shamt", 32'(shamt_o), 32'd0);
    chk("rst_valid", 32'(shamt_valid_o), 32'd0);
    chk("rst_exp", 32'(blk_exp_o), 32'd0);
    chk("rst_tready", 32'(s_if.tready), 32'd1);
    @(negedge cr.clk);
    cr.rstn = 1'b1;

    // Three beats of 0x10: headroom 2, no shift needed.
    send(32'h10101010, 1'b0, 1'b0);
    chk("a_nopulse", 32'(shamt_valid_o), 32'd0);
    send(32'h10101010, 1'b0, 1'b0);
    send(32'h10101010, 1'b1, 1'b0);
    chk("a_pulse", 32'(shamt_valid_o), 32'd1);
    chk("a_shamt", 32'(shamt_o), 32'd0);
    chk("a_exp", 32'(blk_exp_o), 32'd0);
    tick();
    chk("a_pulse_end", 32'(shamt_valid_o), 32'd0);

    // 0x7F early in the stage must survive to the tlast beat.
    send(32'h107F1010, 1'b0, 1'b0);
    send(32'h10101010, 1'b0, 1'b0);
    send(32'h10101010, 1'b1, 1'b0);
    chk("b_shamt", 32'(shamt_o), 32'd2);
    chk("b_exp", 32'(blk_exp_o), 32'd2);
    send(32'hC0101010, 1'b1, 1'b0);
    chk("b2_shamt", 32'(shamt_o), 32'd1);
    chk("b2_exp", 32'(blk_exp_o), 32'd3);
    send(32'h10101010, 1'b0, 1'b0);
    chk("hold_shamt", 32'(shamt_o), 32'd1);
    chk("hold_valid", 32'(shamt_valid_o), 32'd0);
    send(32'h10101010, 1'b1, 1'b0);
    chk("b3_shamt", 32'(shamt_o), 32'd0);
    chk("b3_exp", 32'(blk_exp_o), 32'd3);

    // Table of single-beat stages starting from a cleared exponent.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_exp", 32'(blk_exp_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].lanes, 1'b1, 1'b0);
      chk($sformatf("vec%0d_shamt", i), 32'(shamt_o), 32'(vecs[i].shamt));
      chk($sformatf("vec%0d_exp", i), 32'(blk_exp_o), 32'(vecs[i].bexp));
      chk($sformatf("vec%0d_valid", i), 32'(shamt_valid_o), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].lanes));
      chk($sformatf("vec%0d_tlast", i), 32'(m_if.tlast), 32'd1);
    end

    // Exponent saturation: +2 per stage from 0.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 128; i++) begin
      send(32'h7F101010, 1'b1, 1'b0);
      if (i == 126) chk("sat_254", 32'(blk_exp_o), 32'd254);
    end
    chk("sat_255", 32'(blk_exp_o), 32'd255);
    send(32'h7F101010, 1'b1, 1'b0);
    chk("sat_hold", 32'(blk_exp_o), 32'd255);

    // Back-pressure: drain, then 8 beats against tready 1010...
    tick();
    chk("bp_empty", 32'(m_if.tvalid), 32'd0);
    sent  = 0;
    rcvd  = 0;
    mfull = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      m_if.tready = (cyc % 2 == 0);
      s_if.tvalid = (sent < 8);
      data_i      = mk(sent);
      s_if.tlast  = (sent == 7);
      #1;
      exp_tready = !mfull || m_if.tready;
      chk("bp_tready", 32'(s_if.tready), 32'(exp_tready));
      chk("bp_tvalid", 32'(m_if.tvalid), 32'(mfull));
      in_hs  = s_if.tvalid && exp_tready;
      out_hs = mfull && m_if.tready;
      if (out_hs) begin
        chk("bp_data", 32'(data_o), 32'(exp_q[0]));
        chk("bp_last", 32'(m_if.tlast), 32'(rcvd == 7));
        void'(exp_q.pop_front());
        rcvd++;
      end
      if (in_hs) begin
        exp_q.push_back(data_i);
        sent++;
      end
      tick();
      if (in_hs) mfull = 1'b1;
      else if (out_hs) mfull = 1'b0;
    end
    chk("bp_count", 32'(rcvd), 32'd8);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    tick();

    // clear on the tlast beat of a stage that would need a shift.
    send(32'h7F101010, 1'b0, 1'b0);
    send(32'h1020E0FF, 1'b1, 1'b1);
    chk("clr_valid", 32'(shamt_valid_o), 32'd0);
    chk("clr_shamt", 32'(shamt_o), 32'd0);
    chk("clr_exp0", 32'(blk_exp_o), 32'd0);
    chk("clr_tvalid", 32'(m_if.tvalid), 32'd1);
    chk("clr_data", 32'(data_o), 32'h1020E0FF);
    tick();
    chk("clr_valid2", 32'(shamt_valid_o), 32'd0);
    send(32'h10101010, 1'b1, 1'b0);
    chk("clr_next_shamt", 32'(shamt_o), 32'd0);
    chk("clr_next_valid", 32'(shamt_valid_o), 32'd1);

    // Async reset with a full slice in the middle of a stage.
    send(32'h7F101010, 1'b1, 1'b0);
    chk("ar_pre_shamt", 32'(shamt_o), 32'd2);
    m_if.tready = 1'b0;
    send(32'h7F101010, 1'b0, 1'b0);
    chk("ar_full", 32'(m_if.tvalid), 32'd1);
    #2;
    cr.rstn = 1'b0;
    #1;
    chk("ar_data", 32'(data_o), 32'h0);
    chk("ar_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("ar_tlast", 32'(m_if.tlast), 32'd0);
    chk("ar_shamt", 32'(shamt_o), 32'd0);
    chk("ar_valid", 32'(shamt_valid_o), 32'd0);
    chk("ar_exp", 32'(blk_exp_o), 32'd0);
    @(negedge cr.clk);
    cr.rstn     = 1'b1;
    m_if.tready = 1'b1;
    send(32'h00000000, 1'b1, 1'b0);
    chk("ar_post_shamt", 32'(shamt_o), 32'd0);
    chk("ar_post_valid", 32'(shamt_valid_o), 32'd1);
    chk("ar_post_exp", 32'(blk_exp_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
